pipe_hazard_ctrl: RTL and testbench

- Sequences the IF/ID and ID/EX pipeline buffers by generating hold, flush and bubble controls.
- Detects load-use hazards between the instruction in ID and a load in EX.
- Flushes wrong-path instructions when EX resolves a taken branch or a jump.
- Freezes the front end on an external memory stall, and keeps saturating performance counters of stall and flush events.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Register-index width carried through ID/EX (rd, rs, rt fields).
    localparam int REG_W = 6;

    // Architectural zero register; writes to it are discarded.
    localparam logic [REG_W-1:0] ZERO_REG = 6'd0;

    // Controller states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

    // ID/EX control fields; a bubble loads every field with zero.
    typedef struct packed {
        logic regwrt;
        logic memwrt;
        logic memrd;
        logic branch;
        logic jump;
    } idex_ctrl_t;

    localparam idex_ctrl_t BUBBLE_CTRL = '{
        regwrt: 1'b0,
        memwrt: 1'b0,
        memrd:  1'b0,
        branch: 1'b0,
        jump:   1'b0
    };

    // Larger of two cycle counts, used to size the down-counter.
    function automatic int max_cyc(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX hazard inputs in one direction,
// pipeline-buffer controls and performance counters in the other.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 6,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs_idx;
    logic [REG_W-1:0] id_rt_idx;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memrd;
    logic             ex_regwrt;
    logic             redirect;
    logic             ext_stall;

    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_hold;
    logic             idex_bubble;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies hazard information, consumes controls.
    modport master (
        output id_rs_idx, id_rt_idx, id_uses_rs, id_uses_rt,
        output ex_rd, ex_memrd, ex_regwrt, redirect, ext_stall,
        input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
        input  busy, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs_idx, id_rt_idx, id_uses_rs, id_uses_rt,
        input  ex_rd, ex_memrd, ex_regwrt, redirect, ext_stall,
        output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
        output busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    // Count up on i_inc until all-ones, clear has priority
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and
// external-stall freeze for the IF/ID and ID/EX buffers. Controls are
// Mealy (state + current inputs); state and counters update on clk.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W         = pipe_ctrl_pkg::REG_W,
    parameter int LU_STALL_CYC  = 1,
    parameter int FLUSH_CYC     = 2,
    parameter int CNT_W         = 16,
    parameter int ZERO_REG_HARD = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int MAX_CYC = max_cyc(LU_STALL_CYC, FLUSH_CYC);
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [CYC_W-1:0] r_cyc_left;
    logic [CYC_W-1:0] w_cyc_nxt;

    logic             w_rd_ok;
    logic             w_lu;
    logic             w_pc_hold;
    logic             w_ifid_hold;
    logic             w_ifid_flush;
    logic             w_idex_hold;
    logic             w_idex_bubble;
    logic             w_busy;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_clear;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    // A load into the zero register can never feed a real value forward.
    assign w_rd_ok = (bus.ex_rd != REG_W'(ZERO_REG)) || (ZERO_REG_HARD == 0);

    assign w_lu = bus.ex_memrd && bus.ex_regwrt && w_rd_ok &&
                  ((bus.id_uses_rs && (bus.ex_rd == bus.id_rs_idx)) ||
                   (bus.id_uses_rt && (bus.ex_rd == bus.id_rt_idx)));

    // State and remaining-cycle register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_cyc_left <= {CYC_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_cyc_left <= w_cyc_nxt;
        end
    end

    // Next state: ext_stall freezes, redirect overrides, then load-use
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc_left;
        if (bus.ext_stall) begin
            w_state_nxt = r_state;
            w_cyc_nxt   = r_cyc_left;
        end else if (bus.redirect) begin
            if (FLUSH_CYC > 1) begin
                w_state_nxt = FLUSH;
                w_cyc_nxt   = CYC_W'(FLUSH_CYC - 1);
            end else begin
                w_state_nxt = RUN;
                w_cyc_nxt   = {CYC_W{1'b0}};
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (w_lu && (LU_STALL_CYC > 1)) begin
                        w_state_nxt = LU_STALL;
                        w_cyc_nxt   = CYC_W'(LU_STALL_CYC - 1);
                    end else begin
                        w_state_nxt = RUN;
                        w_cyc_nxt   = {CYC_W{1'b0}};
                    end
                end
                LU_STALL, FLUSH: begin
                    if (r_cyc_left <= CYC_W'(1)) begin
                        w_state_nxt = RUN;
                        w_cyc_nxt   = {CYC_W{1'b0}};
                    end else begin
                        w_state_nxt = r_state;
                        w_cyc_nxt   = r_cyc_left - CYC_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cyc_nxt   = {CYC_W{1'b0}};
                end
            endcase
        end
    end

    // Mealy buffer controls and counter increments
    always_comb begin
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_hold   = 1'b0;
        w_idex_bubble = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        w_busy        = 1'b0;
        if (!rst_n) begin
            // Keep the front end parked and the back end empty in reset.
            w_pc_hold     = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else begin
            w_busy = (r_state != RUN);
            if (bus.ext_stall) begin
                w_pc_hold   = 1'b1;
                w_ifid_hold = 1'b1;
                w_idex_hold = 1'b1;
            end else if (bus.redirect) begin
                // PC loads the target while wrong-path work is discarded.
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_flush_inc   = 1'b1;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_lu) begin
                            w_pc_hold     = 1'b1;
                            w_ifid_hold   = 1'b1;
                            w_idex_bubble = 1'b1;
                            w_stall_inc   = 1'b1;
                        end else begin
                            w_stall_inc   = 1'b0;
                        end
                    end
                    LU_STALL: begin
                        w_pc_hold     = 1'b1;
                        w_ifid_hold   = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_stall_inc   = 1'b1;
                    end
                    FLUSH: begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end
                    default: begin
                        w_idex_bubble = 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_clear = ~rst_n;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_clear (w_clear),
        .i_inc   (w_stall_inc),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .i_clear (w_clear),
        .i_inc   (w_flush_inc),
        .o_count (w_flush_cnt)
    );

    assign bus.pc_hold     = w_pc_hold;
    assign bus.ifid_hold   = w_ifid_hold;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_hold   = w_idex_hold;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.busy        = w_busy;
    assign bus.stall_cnt   = w_stall_cnt;
    assign bus.flush_cnt   = w_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. dut_a: LU_STALL_CYC=1, FLUSH_CYC=2,
// 16-bit counters. dut_b: LU_STALL_CYC=3, FLUSH_CYC=2, 4-bit counters so
// saturation is reachable quickly. Output vectors are packed as
// {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, busy}.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(6), .CNT_W(16)) ia ();
    pipe_hazard_ctrl_if #(.REG_W(6), .CNT_W(4))  ib ();

    pipe_hazard_ctrl #(.REG_W(6), .LU_STALL_CYC(1), .FLUSH_CYC(2),
                       .CNT_W(16), .ZERO_REG_HARD(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

    pipe_hazard_ctrl #(.REG_W(6), .LU_STALL_CYC(3), .FLUSH_CYC(2),
                       .CNT_W(4), .ZERO_REG_HARD(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b110010;
    localparam logic [5:0] O_LUB   = 6'b110011;
    localparam logic [5:0] O_FL    = 6'b001010;
    localparam logic [5:0] O_FLB   = 6'b001011;
    localparam logic [5:0] O_EXT   = 6'b110100;
    localparam logic [5:0] O_EXTB  = 6'b110101;
    localparam logic [5:0] O_RST   = 6'b101010;

    typedef struct {
        string      nm;
        logic [5:0] rs, rt, rd;
        logic       urs, urt, memrd, regwrt, redir, ext;
        logic [5:0] eo;
        int         est, efl;
    } vec_t;

    vec_t tv[12];

    function automatic vec_t mk(input string nm, input logic [5:0] rs, rt, rd,
                                input logic urs, urt, memrd, regwrt, redir, ext,
                                input logic [5:0] eo, input int est, efl);
        vec_t v;
        v.nm = nm; v.rs = rs; v.rt = rt; v.rd = rd;
        v.urs = urs; v.urt = urt; v.memrd = memrd; v.regwrt = regwrt;
        v.redir = redir; v.ext = ext; v.eo = eo; v.est = est; v.efl = efl;
        return v;
    endfunction

    task automatic drive(input logic [5:0] rs, rt, rd,
                         input logic urs, urt, memrd, regwrt, redir, ext);
        ia.id_rs_idx = rs;  ib.id_rs_idx = rs;
        ia.id_rt_idx = rt;  ib.id_rt_idx = rt;
        ia.ex_rd     = rd;  ib.ex_rd     = rd;
        ia.id_uses_rs = urs; ib.id_uses_rs = urs;
        ia.id_uses_rt = urt; ib.id_uses_rt = urt;
        ia.ex_memrd  = memrd;  ib.ex_memrd  = memrd;
        ia.ex_regwrt = regwrt; ib.ex_regwrt = regwrt;
        ia.redirect  = redir;  ib.redirect  = redir;
        ia.ext_stall = ext;    ib.ext_stall = ext;
    endtask

    task automatic idle();
        drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lu5();
        drive(6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic redir();
        drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ext();
        drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs_a();
        return {ia.pc_hold, ia.ifid_hold, ia.ifid_flush,
                ia.idex_hold, ia.idex_bubble, ia.busy};
    endfunction

    function automatic logic [5:0] outs_b();
        return {ib.pc_hold, ib.ifid_hold, ib.ifid_flush,
                ib.idex_hold, ib.idex_bubble, ib.busy};
    endfunction

    task automatic chk_out(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: outputs got %b, expected %b", nm, got, exp);
        end
        n_cmp++;
        if ((got[4] & got[3]) || (got[2] & got[1])) begin
            n_err++;
            $display("FAIL %s_excl: hold/flush or hold/bubble both set in %b", nm, got);
        end
    endtask

    task automatic chk_cnt(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: count got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        next_cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        tv[0]  = mk("idle",      6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 0, 0);
        tv[1]  = mk("lu_rs",     6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_LU,   1, 0);
        tv[2]  = mk("lu_rt",     6'd3, 6'd9, 6'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_LU,   1, 0);
        tv[3]  = mk("zero_reg",  6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_IDLE, 0, 0);
        tv[4]  = mk("rt_unused", 6'd1, 6'd7, 6'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_IDLE, 0, 0);
        tv[5]  = mk("no_memrd",  6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, 0, 0);
        tv[6]  = mk("no_regwrt", 6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, 0, 0);
        tv[7]  = mk("rs_differ", 6'd6, 6'd4, 6'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_IDLE, 0, 0);
        tv[8]  = mk("redirect",  6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FL,   0, 1);
        tv[9]  = mk("redir_lu",  6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_FL,   0, 1);
        tv[10] = mk("ext_all",   6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_EXT,  0, 0);
        tv[11] = mk("ext_only",  6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_EXT,  0, 0);

        // Reset state: forced outputs while rst_n is low, counters cleared.
        rst_n = 1'b0;
        idle();
        next_cyc();
        @(negedge clk);
        chk_out("rst_outs_a", outs_a(), O_RST);
        chk_out("rst_outs_b", outs_b(), O_RST);
        chk_cnt("rst_stall_a", int'(ia.stall_cnt), 0);
        chk_cnt("rst_flush_a", int'(ia.flush_cnt), 0);
        next_cyc();
        rst_n = 1'b1;

        // Single-cycle vectors from RUN, each followed by a counter check.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(tv[i].rs, tv[i].rt, tv[i].rd, tv[i].urs, tv[i].urt,
                  tv[i].memrd, tv[i].regwrt, tv[i].redir, tv[i].ext);
            @(negedge clk);
            chk_out({tv[i].nm, "_out"}, outs_a(), tv[i].eo);
            next_cyc();
            idle();
            @(negedge clk);
            chk_cnt({tv[i].nm, "_stall"}, int'(ia.stall_cnt), tv[i].est);
            chk_cnt({tv[i].nm, "_flush"}, int'(ia.flush_cnt), tv[i].efl);
            next_cyc();
        end

        // Load-use then release: next cycle back in RUN with no controls.
        do_reset();
        lu5();
        @(negedge clk); chk_out("lu1_c0", outs_a(), O_LU);
        next_cyc(); idle();
        @(negedge clk); chk_out("lu1_c1", outs_a(), O_IDLE);
        chk_cnt("lu1_stall", int'(ia.stall_cnt), 1);
        next_cyc();

        // Redirect pulse: two flush cycles, busy only on the second.
        do_reset();
        redir();
        @(negedge clk); chk_out("rd_c0", outs_a(), O_FL);
        next_cyc(); idle();
        @(negedge clk); chk_out("rd_c1", outs_a(), O_FLB);
        next_cyc();
        @(negedge clk); chk_out("rd_c2", outs_a(), O_IDLE);
        chk_cnt("rd_flush", int'(ia.flush_cnt), 1);
        chk_cnt("rd_stall", int'(ia.stall_cnt), 0);
        next_cyc();

        // Redirect aborting a 3-cycle load-use stall (dut_b).
        do_reset();
        lu5();
        @(negedge clk); chk_out("ab_c0", outs_b(), O_LU);
        next_cyc(); idle();
        @(negedge clk); chk_out("ab_c1", outs_b(), O_LUB);
        next_cyc(); redir();
        @(negedge clk); chk_out("ab_c2", outs_b(), O_FLB);
        next_cyc(); idle();
        @(negedge clk); chk_out("ab_c3", outs_b(), O_FLB);
        chk_cnt("ab_stall", int'(ib.stall_cnt), 2);
        chk_cnt("ab_flush", int'(ib.flush_cnt), 1);
        next_cyc();
        @(negedge clk); chk_out("ab_c4", outs_b(), O_IDLE);
        chk_cnt("ab_stall_end", int'(ib.stall_cnt), 2);
        next_cyc();

        // ext_stall for 4 cycles in the middle of a flush.
        do_reset();
        redir();
        @(negedge clk); chk_out("es_c0", outs_a(), O_FL);
        for (int k = 0; k < 4; k++) begin
            next_cyc(); ext();
            @(negedge clk); chk_out("es_hold", outs_a(), O_EXTB);
        end
        next_cyc(); idle();
        @(negedge clk); chk_out("es_resume", outs_a(), O_FLB);
        next_cyc();
        @(negedge clk); chk_out("es_done", outs_a(), O_IDLE);
        chk_cnt("es_flush", int'(ia.flush_cnt), 1);
        next_cyc();

        // Saturation on the 4-bit counter: 3 bubble cycles per hazard.
        do_reset();
        for (int h = 0; h < 6; h++) begin
            lu5();
            next_cyc(); idle();
            next_cyc();
            next_cyc();
            @(negedge clk);
            if (h == 3) chk_cnt("sat_12", int'(ib.stall_cnt), 12);
            if (h == 4) chk_cnt("sat_15", int'(ib.stall_cnt), 15);
            if (h == 5) chk_cnt("sat_hold", int'(ib.stall_cnt), 15);
        end
        chk_cnt("sat_flush", int'(ib.flush_cnt), 0);

        // Reset in the middle of a load-use stall.
        next_cyc(); lu5();
        next_cyc(); idle(); rst_n = 1'b0;
        @(negedge clk); chk_out("rs_mid", outs_b(), O_RST);
        next_cyc(); rst_n = 1'b1;
        @(negedge clk); chk_out("rs_after", outs_b(), O_IDLE);
        chk_cnt("rs_stall", int'(ib.stall_cnt), 0);
        chk_cnt("rs_flush", int'(ib.flush_cnt), 0);
        next_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
